seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle core ALU.
- Widens the datapath to XLEN and extends the operation set to shifts, XOR, SLTU, multiply-low, unsigned divide and unsigned remainder.
- Sits in the execute stage behind a valid/ready handshake, so the control unit can stall on long operations.
- Single-cycle ops complete in one cycle; MUL/DIVU/REMU are iterative, one bit per cycle.

Parameters:
- XLEN, 32, datapath width in bits; must be a power of two, 8 or more.
- SHAMT_W, $clog2(XLEN), derived; shift-amount width, taken from srcB[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  srcA/srcB/ALUControl are valid this cycle
- in_ready  output  1  block can accept an operation
- srcA  input  XLEN  operand A
- srcB  input  XLEN  operand B
- ALUControl  input  4  operation select (encoding below)
- out_valid  output  1  ALUResult/Zero are valid
- out_ready  input  1  consumer takes the result this cycle
- ALUResult  output  XLEN  registered result
- Zero  output  1  registered; high when ALUResult == 0
- busy  output  1  high in the MUL or DIV state

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- Reset values: in_ready=1, out_valid=0, ALUResult=0, Zero=1, busy=0, state=IDLE.
- Reset mid-operation aborts the operation and discards partial results; the next cycle is IDLE.
- ALUControl encoding (3-bit legacy codes kept as 0xxx):
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor
  - 0101 slt (signed); 0110 sltu; 0111 sll; 1000 srl; 1001 sra
  - 1010 mul (low XLEN bits); 1011 divu; 1100 remu
  - 1101-1111 reserved: result 0
- slt/sltu return {XLEN-1 zeros, flag}.
- add/sub wrap modulo 2^XLEN; no overflow flag.
- Shifts use srcB[SHAMT_W-1:0] only.
- Acceptance: an operation is accepted when in_valid && in_ready. in_ready = (state==IDLE).
- States: IDLE, MUL, DIV, DONE.
  - IDLE, single-cycle op (including reserved codes) accepted: compute, register result, go to DONE. out_valid rises on the next cycle (latency 1).
  - IDLE, mul accepted: latch operands, clear accumulator and counter, go to MUL.
  - IDLE, divu/remu accepted, srcB != 0: latch operands, go to DIV.
  - IDLE, divu/remu accepted, srcB == 0: go directly to DONE. divu result = all ones; remu result = srcA (latency 1).
  - MUL: shift-add, one multiplier bit per cycle, XLEN cycles, then DONE. Accept-to-out_valid latency = XLEN+1.
  - DIV: restoring divide, one quotient bit per cycle, XLEN cycles, then DONE with the quotient or remainder per the latched op. Latency = XLEN+1.
  - DONE: out_valid=1. ALUResult and Zero stay stable until out_ready. On out_ready, go to IDLE; out_valid drops next cycle.
- Throughput: at most one operation per 2 cycles. No acceptance in DONE.
- in_valid while in_ready=0 is ignored. The producer must hold its request until accepted.
- ALUControl/srcA/srcB changes after acceptance do not affect the operation in flight; operands and op are latched.
- busy is high exactly in MUL and DIV.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e: 4-bit enum of the encodings above
  - alu_state_e: IDLE/MUL/DIV/DONE
  - default XLEN localparam
  - is_multicycle(op) function
- One natural sub-module, iter_muldiv:
  - holds the shared XLEN-cycle shift-add multiplier / restoring divider datapath and counter
  - interface: start, op, a, b, done, result
- The top keeps the FSM, the single-cycle ops and the handshake.

Test Plan:
- Reset then add: srcA=7, srcB=-3 (0xFFFFFFFD), ALUControl=0000, in_valid for 1 cycle -> out_valid next cycle, ALUResult=4, Zero=0. Then out_ready=1 -> in_ready back to 1 the following cycle.
- Shifts/compares: sra 0x80000000 by srcB=0x21 -> 0xC0000000 (shamt=1); sltu 1 vs 0xFFFFFFFF -> 1; slt 1 vs 0xFFFFFFFF -> 0; sub 5-5 -> 0 with Zero=1.
- mul: 0x0001_0003 * 0x0000_0010 -> 0x0010_0030, out_valid exactly 33 cycles after acceptance. busy high 32 cycles. in_ready=0 throughout, and an in_valid pulse during the operation is ignored.
- divu/remu: 100/7 -> 14; 100%7 -> 2, each with 33-cycle latency. Divide by zero: divu 5/0 -> 0xFFFFFFFF, remu 5%0 -> 5, both with latency 1.
- Backpressure: out_ready held low 5 cycles after a result -> ALUResult/Zero constant, out_valid stays 1, in_ready stays 0.
- Reset mid-mul at cycle 10: assert reset 1 cycle -> next cycle in_ready=1, out_valid=0, ALUResult=0. A following add 2+2 returns 4.

Source files
------------

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared types and helpers for the seq_alu execute-stage ALU:
//             operation encodings, FSM state names, default datapath width
//             and the multi-cycle operation classifier.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Codes 0000-0111 keep the legacy 3-bit ALU meanings; 1101-1111 reserved.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_DIVU = 4'b1011,
        ALU_REMU = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    function automatic logic is_multicycle(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Request/response bundle between the control unit (master) and
//             the seq_alu execute block (slave).
//  Signals  : in_valid/in_ready, srcA, srcB, ALUControl  - request side
//             out_valid/out_ready, ALUResult, Zero      - response side
//             busy                                       - iterative op running
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [3:0]      ALUControl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            busy;

    modport master (
        output in_valid, srcA, srcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, srcA, srcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : iter_muldiv
//  Purpose  : Shared iterative datapath: shift-add multiplier (low XLEN bits)
//             and restoring unsigned divider, one bit per cycle, XLEN cycles.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             start_i     - latch operands/op and begin an XLEN-step run
//             op_i        - ALU_MUL, ALU_DIVU or ALU_REMU
//             a_i, b_i    - operands (b_i must be non-zero for divides)
//             done_o      - high during the last step of a run
//             result_o    - final result, valid while done_o is high
//  Revision : 1.0 - initial release
// ============================================================================
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            start_i,
    input  alu_op_e              op_i,
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [XLEN-1:0] b_i,
    output logic                 done_o,
    output logic [XLEN-1:0]      result_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    // Register roles shared between the two algorithms:
    //   acc : product accumulator        | partial remainder
    //   opa : multiplicand, shifts left  | dividend in, quotient bits out
    //   opb : multiplier, shifts right   | divisor (constant)
    alu_op_e            op_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]    opa_q, opa_d;
    logic [XLEN-1:0]    opb_q, opb_d;

    logic               running;
    logic               is_mul;
    logic [XLEN:0]      rem_shift;
    logic [XLEN:0]      rem_diff;
    logic [XLEN-1:0]    step_acc;
    logic [XLEN-1:0]    step_opa;
    logic [XLEN-1:0]    step_opb;

    assign running = (cnt_q != '0);
    assign is_mul  = (op_q == ALU_MUL);

    // Bring the next dividend bit into the remainder and try the subtract;
    // bit XLEN of the difference is the borrow (remainder < divisor).
    assign rem_shift = {acc_q, opa_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_q};

    always_comb begin
        step_acc = acc_q;
        step_opa = opa_q;
        step_opb = opb_q;
        if (is_mul) begin
            step_acc = acc_q + (opb_q[0] ? opa_q : '0);
            step_opa = opa_q << 1;
            step_opb = opb_q >> 1;
        end else if (!rem_diff[XLEN]) begin
            step_acc = rem_diff[XLEN-1:0];
            step_opa = {opa_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = rem_shift[XLEN-1:0];
            step_opa = {opa_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        if (start_i) begin
            cnt_d = CNT_W'(XLEN);
            acc_d = '0;
            opa_d = a_i;
            opb_d = b_i;
        end else if (running) begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = step_acc;
            opa_d = step_opa;
            opb_d = step_opb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= ALU_ADD;
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            if (start_i) begin
                op_q <= op_i;
            end
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    // Result comes from the last step's next values so the caller can
    // register it on the same edge that finishes the run.
    assign done_o   = (cnt_q == CNT_W'(1));
    assign result_o = (is_mul || (op_q == ALU_REMU)) ? step_acc : step_opa;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multi-cycle execute-stage ALU behind a valid/ready handshake.
//             Single-cycle ops return after one cycle; MUL/DIVU/REMU iterate
//             one bit per cycle in iter_muldiv.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous active-high reset
//             bus    - seq_alu_if.slave: in_valid/in_ready, srcA, srcB,
//                      ALUControl, out_valid/out_ready, ALUResult, Zero, busy
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    seq_alu_if.slave   bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MUL  = MUL;
    localparam logic [1:0] S_DIV  = DIV;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;

    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               b_is_zero;
    logic               md_start;
    logic               md_done;
    logic [XLEN-1:0]    md_result;
    logic [XLEN-1:0]    single_res;

    assign op        = alu_op_e'(bus.ALUControl);
    assign shamt     = bus.srcB[SHAMT_W-1:0];
    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign b_is_zero = (bus.srcB == '0);

    // Divide by zero never enters the iterative unit; its result is a
    // one-cycle constant produced by the single-cycle path below.
    assign md_start  = accept && is_multicycle(op) && !((op != ALU_MUL) && b_is_zero);

    always_comb begin
        single_res = '0;
        case (op)
            ALU_ADD:  single_res = bus.srcA + bus.srcB;
            ALU_SUB:  single_res = bus.srcA - bus.srcB;
            ALU_AND:  single_res = bus.srcA & bus.srcB;
            ALU_OR:   single_res = bus.srcA | bus.srcB;
            ALU_XOR:  single_res = bus.srcA ^ bus.srcB;
            ALU_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
            ALU_SLTU: single_res = {{(XLEN-1){1'b0}}, (bus.srcA < bus.srcB)};
            ALU_SLL:  single_res = bus.srcA << shamt;
            ALU_SRL:  single_res = bus.srcA >> shamt;
            ALU_SRA:  single_res = $unsigned($signed(bus.srcA) >>> shamt);
            ALU_DIVU: single_res = '1;
            ALU_REMU: single_res = bus.srcA;
            default:  single_res = '0;
        endcase
    end

    iter_muldiv #(
        .XLEN     (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .op_i     (op),
        .a_i      (bus.srcA),
        .b_i      (bus.srcB),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (md_start) begin
                        state_d = (op == ALU_MUL) ? S_MUL : S_DIV;
                    end else begin
                        state_d  = S_DONE;
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_done) begin
                    state_d  = S_DONE;
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu: directed cases from the
//             operation table plus randomized traffic against a behavioural
//             model that tracks latency and results arithmetically.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.XLEN(XLEN)) bus();

    seq_alu #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation table.
    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return $unsigned($signed(a) >>> sh);
            4'd10:   return a * b;
            4'd11:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10) return XLEN + 1;
        if ((op == 4'd11 || op == 4'd12) && b != 0) return XLEN + 1;
        return 1;
    endfunction

    // Behavioural model: idle / counting down an iterative op / holding a result.
    logic        m_live = 1'b0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_live <= 1'b1;
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_live) begin
            if (m_done) begin
                if (bus.out_ready) m_done <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end else if (bus.in_valid) begin
                if (lat_of(bus.ALUControl, bus.srcB) == 1) begin
                    m_done <= 1'b1;
                    m_res  <= ref_op(bus.ALUControl, bus.srcA, bus.srcB);
                end else begin
                    m_left <= XLEN;
                    m_pend <= ref_op(bus.ALUControl, bus.srcA, bus.srcB);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_in_ready",  32'(bus.in_ready),  32'(!m_done && m_left == 0));
            check("m_out_valid", 32'(bus.out_valid), 32'(m_done));
            check("m_busy",      32'(bus.busy),      32'(m_left > 0));
            check("m_result",    bus.ALUResult,      m_res);
            check("m_zero",      32'(bus.Zero),      32'(m_res == 0));
        end
    end

    // Issue one op from IDLE, wait for the result, check value and latency.
    // With pulse set, a stray in_valid is raised mid-operation.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit pulse);
        int lat;
        int busy_cnt;
        bit ready_seen;
        @(negedge clk);
        check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.ALUControl = op;
        bus.srcA       = a;
        bus.srcB       = b;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.ALUControl = 4'($urandom_range(0, 15));
        bus.srcA       = $urandom;
        bus.srcB       = $urandom;
        lat        = 1;
        busy_cnt   = 0;
        ready_seen = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.in_ready === 1'b1) ready_seen = 1'b1;
            bus.in_valid = pulse && (lat == 5);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({name, "_no_ready"}, 32'(ready_seen), 32'd0);
        check({name, "_result"}, bus.ALUResult, exp);
        check({name, "_zero"}, 32'(bus.Zero), 32'(exp == 0));
    endtask

    // Hold off the consumer for some cycles, then take the result.
    task automatic release_result(input string name, input int hold);
        logic [31:0] r0;
        logic        z0;
        r0 = bus.ALUResult;
        z0 = bus.Zero;
        repeat (hold) begin
            @(negedge clk);
            check({name, "_hold_result"}, bus.ALUResult, r0);
            check({name, "_hold_zero"}, 32'(bus.Zero), 32'(z0));
            check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_back_ready"}, 32'(bus.in_ready), 32'd1);
        check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.srcA       = '0;
        bus.srcB       = '0;
        bus.ALUControl = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.ALUResult,      32'd0);
        check("rst_zero",      32'(bus.Zero),      32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        reset = 1'b0;

        // Hand-computed directed cases.
        do_op("add",      4'b0000, 32'd7,          32'hFFFF_FFFD, 32'd4,          1,  1'b0); release_result("add", 0);
        do_op("sra",      4'b1001, 32'h8000_0000,  32'h21,        32'hC000_0000,  1,  1'b0); release_result("sra", 0);
        do_op("sltu",     4'b0110, 32'd1,          32'hFFFF_FFFF, 32'd1,          1,  1'b0); release_result("sltu", 0);
        do_op("slt",      4'b0101, 32'd1,          32'hFFFF_FFFF, 32'd0,          1,  1'b0); release_result("slt", 0);
        do_op("sub",      4'b0001, 32'd5,          32'd5,         32'd0,          1,  1'b0); release_result("sub", 0);
        do_op("mul",      4'b1010, 32'h0001_0003,  32'h10,        32'h0010_0030,  33, 1'b1); release_result("mul", 0);
        do_op("divu",     4'b1011, 32'd100,        32'd7,         32'd14,         33, 1'b1); release_result("divu", 0);
        do_op("remu",     4'b1100, 32'd100,        32'd7,         32'd2,          33, 1'b0); release_result("remu", 0);
        do_op("divu0",    4'b1011, 32'd5,          32'd0,         32'hFFFF_FFFF,  1,  1'b0); release_result("divu0", 0);
        do_op("remu0",    4'b1100, 32'd5,          32'd0,         32'd5,          1,  1'b0); release_result("remu0", 5);
        do_op("reserved", 4'b1110, 32'd9,          32'd9,         32'd0,          1,  1'b0); release_result("reserved", 2);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.ALUControl = 4'b1010;
        bus.srcA       = 32'd1234;
        bus.srcB       = 32'd5678;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result",    bus.ALUResult,      32'd0);
        do_op("post_rst_add", 4'b0000, 32'd2, 32'd2, 32'd4, 1, 1'b0); release_result("post_rst_add", 0);

        // Randomized traffic; the model process checks every cycle as well.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = $urandom_range(1, 40);
            else               b = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
            do_op("rand", op, a, b, ref_op(op, a, b), lat_of(op, b), $urandom_range(0, 1) == 1);
            release_result("rand", $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
